// File: rtl/dip_capture.sv
`default_nettype none
// ============================================================================
//  Module   : dip_capture
//  Purpose  : Synchronises and debounces a WIDTH-bit DIP switch bank and one
//             push button, then either latches the (optionally bit-reversed)
//             switch word on each debounced button press or tracks the
//             switches continuously.
//  Ports    : clk           - system clock
//             rst           - asynchronous active-high reset
//             dip_in        - raw switch pins (asynchronous)
//             btn_in        - raw button pin (asynchronous, active-high)
//             live_mode     - 1 = track switches, 0 = latch on press
//             value         - captured word after bit mapping
//             capture_pulse - one-cycle strobe when value is loaded/changes
//             btn_level     - debounced button level
//             changed       - value differs from the mapped debounced switches
//  Revision : 1.0 - initial release
// ============================================================================
module dip_capture #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter bit REVERSE         = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dip_in,
  input  logic             btn_in,
  input  logic             live_mode,
  output logic [WIDTH-1:0] value,
  output logic             capture_pulse,
  output logic             btn_level,
  output logic             changed
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  // Two-flop synchronisers
  logic [WIDTH-1:0] dip_s1_q, dip_s1_d, dip_s2_q, dip_s2_d;
  logic             btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;

  // Debouncers
  logic [WIDTH-1:0] dip_cand_q, dip_cand_d, dip_stable_q, dip_stable_d;
  logic [CNT_W-1:0] dip_cnt_q, dip_cnt_d;
  logic             btn_cand_q, btn_cand_d, btn_stable_q, btn_stable_d;
  logic [CNT_W-1:0] btn_cnt_q, btn_cnt_d;

  // Capture stage
  logic             btn_prev_q, btn_prev_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             pulse_q, pulse_d;

  logic             w_press;
  logic [WIDTH-1:0] w_mapped;

  // Bit-order mapping of the debounced switch word
  generate
    if (REVERSE) begin : g_reverse
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign w_mapped[WIDTH-1-i] = dip_stable_q[i];
      end
    end else begin : g_straight
      assign w_mapped = dip_stable_q;
    end
  endgenerate

  // Rising edge of the debounced button level
  assign w_press = btn_stable_q & ~btn_prev_q;

  always_comb begin
    dip_s1_d = dip_in;
    dip_s2_d = dip_s1_q;
    btn_s1_d = btn_in;
    btn_s2_d = btn_s1_q;

    // Switch bus debounce: any bit change restarts the whole window.
    dip_cand_d   = dip_cand_q;
    dip_cnt_d    = dip_cnt_q;
    dip_stable_d = dip_stable_q;
    if (dip_s2_q != dip_cand_q) begin
      dip_cand_d = dip_s2_q;
      dip_cnt_d  = '0;
    end else if (dip_cnt_q != CNT_MAX) begin
      dip_cnt_d = dip_cnt_q + 1'b1;
    end else begin
      dip_stable_d = dip_cand_q;
    end

    btn_cand_d   = btn_cand_q;
    btn_cnt_d    = btn_cnt_q;
    btn_stable_d = btn_stable_q;
    if (btn_s2_q != btn_cand_q) begin
      btn_cand_d = btn_s2_q;
      btn_cnt_d  = '0;
    end else if (btn_cnt_q != CNT_MAX) begin
      btn_cnt_d = btn_cnt_q + 1'b1;
    end else begin
      btn_stable_d = btn_cand_q;
    end

    btn_prev_d = btn_stable_q;

    // Capture uses the mapped word as it stands before this edge, so a press
    // coinciding with a debounce update loads the older word.
    value_d = value_q;
    pulse_d = 1'b0;
    if (live_mode) begin
      if (value_q != w_mapped) begin
        value_d = w_mapped;
        pulse_d = 1'b1;
      end
    end else if (w_press) begin
      value_d = w_mapped;
      pulse_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dip_s1_q     <= '0;
      dip_s2_q     <= '0;
      btn_s1_q     <= 1'b0;
      btn_s2_q     <= 1'b0;
      dip_cand_q   <= '0;
      dip_cnt_q    <= '0;
      dip_stable_q <= '0;
      btn_cand_q   <= 1'b0;
      btn_cnt_q    <= '0;
      btn_stable_q <= 1'b0;
      btn_prev_q   <= 1'b0;
      value_q      <= '0;
      pulse_q      <= 1'b0;
    end else begin
      dip_s1_q     <= dip_s1_d;
      dip_s2_q     <= dip_s2_d;
      btn_s1_q     <= btn_s1_d;
      btn_s2_q     <= btn_s2_d;
      dip_cand_q   <= dip_cand_d;
      dip_cnt_q    <= dip_cnt_d;
      dip_stable_q <= dip_stable_d;
      btn_cand_q   <= btn_cand_d;
      btn_cnt_q    <= btn_cnt_d;
      btn_stable_q <= btn_stable_d;
      btn_prev_q   <= btn_prev_d;
      value_q      <= value_d;
      pulse_q      <= pulse_d;
    end
  end

  assign value         = value_q;
  assign capture_pulse = pulse_q;
  assign btn_level     = btn_stable_q;
  assign changed       = (value_q != w_mapped);

endmodule
`default_nettype wire

// File: tb/tb_dip_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dip_capture
//  Purpose  : Self-checking bench for dip_capture (WIDTH=8, D=4, REVERSE=1).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dip_capture;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] dip_in = 8'h00;
  logic       btn_in = 1'b0;
  logic       live_mode = 1'b0;
  logic [7:0] value;
  logic       capture_pulse;
  logic       btn_level;
  logic       changed;

  int checks = 0;
  int failures = 0;

  dip_capture #(
    .WIDTH(8),
    .DEBOUNCE_CYCLES(D),
    .REVERSE(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .dip_in(dip_in),
    .btn_in(btn_in),
    .live_mode(live_mode),
    .value(value),
    .capture_pulse(capture_pulse),
    .btn_level(btn_level),
    .changed(changed)
  );

  always #5 clk = ~clk;

  // Reference model: pins reach the debouncer two edges late; a word is
  // accepted once the last D+2 values seen by the debouncer are identical.
  logic [7:0] pin_d_q[$];
  logic       pin_b_q[$];
  logic [7:0] win_d[$];
  logic       win_b[$];
  logic [7:0] m_dip, m_value;
  logic       m_lvl, m_prev, m_pulse;

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  task automatic model_reset();
    pin_d_q = '{8'h00, 8'h00};
    pin_b_q = '{1'b0, 1'b0};
    win_d   = '{8'h00};
    win_b   = '{1'b0};
    m_dip = 8'h00; m_value = 8'h00;
    m_lvl = 1'b0; m_prev = 1'b0; m_pulse = 1'b0;
  endtask

  task automatic model_step();
    logic [7:0] s2d;
    logic       s2b;
    logic       press;
    logic [7:0] mapped;
    bit         same;
    press  = m_lvl & ~m_prev;
    mapped = rev8(m_dip);
    if (live_mode) begin
      m_pulse = (m_value != mapped);
      m_value = mapped;
    end else if (press) begin
      m_value = mapped;
      m_pulse = 1'b1;
    end else begin
      m_pulse = 1'b0;
    end
    m_prev = m_lvl;
    s2d = pin_d_q.pop_front(); pin_d_q.push_back(dip_in);
    s2b = pin_b_q.pop_front(); pin_b_q.push_back(btn_in);
    win_d.push_back(s2d);
    if (win_d.size() > D + 2) void'(win_d.pop_front());
    win_b.push_back(s2b);
    if (win_b.size() > D + 2) void'(win_b.pop_front());
    if (win_d.size() == D + 2) begin
      same = 1'b1;
      foreach (win_d[i]) if (win_d[i] != s2d) same = 1'b0;
      if (same) m_dip = s2d;
    end
    if (win_b.size() == D + 2) begin
      same = 1'b1;
      foreach (win_b[i]) if (win_b[i] != s2b) same = 1'b0;
      if (same) m_lvl = s2b;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    dip_in = 8'h0F; btn_in = 1'b0; live_mode = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++; if (value !== 8'h00) begin failures++; $display("FAIL reset_value actual=%h expected=00", value); end
    checks++; if (capture_pulse !== 1'b0) begin failures++; $display("FAIL reset_pulse actual=%b expected=0", capture_pulse); end
    checks++; if (btn_level !== 1'b0) begin failures++; $display("FAIL reset_btn_level actual=%b expected=0", btn_level); end
    checks++; if (changed !== 1'b0) begin failures++; $display("FAIL reset_changed actual=%b expected=0", changed); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_latch_idle();
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++; if (value !== 8'h00 || capture_pulse !== 1'b0) begin
        failures++; $display("FAIL idle_hold edge=%0d value=%h pulse=%b expected value=00 pulse=0", k, value, capture_pulse);
      end
      if (k == 7) begin
        checks++; if (changed !== 1'b0) begin failures++; $display("FAIL idle_changed_e7 actual=%b expected=0", changed); end
      end
      if (k == 8) begin
        checks++; if (changed !== 1'b1) begin failures++; $display("FAIL idle_changed_e8 actual=%b expected=1", changed); end
      end
    end
  endtask

  task automatic test_press();
    int pulses;
    btn_in = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 7) begin
        checks++; if (btn_level !== 1'b0) begin failures++; $display("FAIL press_lvl_e7 actual=%b expected=0", btn_level); end
      end
      if (k == 8) begin
        checks++; if (btn_level !== 1'b1) begin failures++; $display("FAIL press_lvl_e8 actual=%b expected=1", btn_level); end
        checks++; if (value !== 8'h00) begin failures++; $display("FAIL press_value_e8 actual=%h expected=00", value); end
      end
      if (k == 9) begin
        checks++; if (value !== 8'hF0) begin failures++; $display("FAIL press_value_e9 actual=%h expected=f0", value); end
        checks++; if (capture_pulse !== 1'b1) begin failures++; $display("FAIL press_pulse_e9 actual=%b expected=1", capture_pulse); end
      end
      if (k == 10) begin
        checks++; if (capture_pulse !== 1'b0 || changed !== 1'b0) begin
          failures++; $display("FAIL press_after_e10 pulse=%b changed=%b expected pulse=0 changed=0", capture_pulse, changed);
        end
      end
    end
    pulses = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (capture_pulse) pulses++;
    end
    checks++; if (pulses != 0 || value !== 8'hF0) begin
      failures++; $display("FAIL press_hold pulses=%0d value=%h expected pulses=0 value=f0", pulses, value);
    end
  endtask

  task automatic test_bounce();
    int pulses, pos;
    btn_in = 1'b0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (capture_pulse) pulses++;
    end
    checks++; if (pulses != 0 || btn_level !== 1'b0) begin
      failures++; $display("FAIL release_event pulses=%0d level=%b expected pulses=0 level=0", pulses, btn_level);
    end
    pulses = 0;
    pos = -1;
    for (int i = 0; i < 12; i++) begin
      btn_in = ((i / 2) % 2 == 0);
      tick();
      if (capture_pulse) pulses++;
    end
    btn_in = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (capture_pulse) begin pulses++; pos = k; end
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL bounce_count actual=%0d expected=1", pulses); end
    checks++; if (pos != 9) begin failures++; $display("FAIL bounce_pos actual=%0d expected=9", pos); end
  endtask

  task automatic test_glitch();
    int bad;
    dip_in = 8'h00; btn_in = 1'b0; live_mode = 1'b0;
    do_reset();
    bad = 0;
    for (int k = 0; k < 33; k++) begin
      dip_in = (k >= 10 && k < 13) ? 8'hFF : 8'h00;
      tick();
      if (changed !== 1'b0 || capture_pulse !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL glitch_filter bad_cycles=%0d expected=0", bad); end
  endtask

  task automatic test_live();
    int bad;
    live_mode = 1'b1;
    dip_in = 8'h01;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 8) begin
        checks++; if (value !== 8'h00) begin failures++; $display("FAIL live_value_e8 actual=%h expected=00", value); end
      end
      if (k == 9) begin
        checks++; if (value !== 8'h80 || capture_pulse !== 1'b1) begin
          failures++; $display("FAIL live_load_e9 value=%h pulse=%b expected value=80 pulse=1", value, capture_pulse);
        end
      end
      if (k == 10) begin
        checks++; if (capture_pulse !== 1'b0) begin failures++; $display("FAIL live_pulse_e10 actual=%b expected=0", capture_pulse); end
      end
    end
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      btn_in = (k < 25);
      tick();
      if (value !== 8'h80 || capture_pulse !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL live_press_ignored bad_cycles=%0d expected=0", bad); end
    live_mode = 1'b0;
    dip_in = 8'h02;
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (value !== 8'h80) bad++;
    end
    checks++; if (bad != 0 || changed !== 1'b1) begin
      failures++; $display("FAIL live_to_latch bad_cycles=%0d changed=%b expected bad=0 changed=1", bad, changed);
    end
    live_mode = 1'b1;
    tick();
    checks++; if (value !== 8'h40 || capture_pulse !== 1'b1) begin
      failures++; $display("FAIL latch_to_live value=%h pulse=%b expected value=40 pulse=1", value, capture_pulse);
    end
    tick();
    checks++; if (capture_pulse !== 1'b0 || changed !== 1'b0) begin
      failures++; $display("FAIL latch_to_live_after pulse=%b changed=%b expected 0 0", capture_pulse, changed);
    end
  endtask

  task automatic test_async_reset();
    live_mode = 1'b1;
    dip_in = 8'h0F;
    for (int k = 0; k < 10; k++) tick();
    checks++; if (value !== 8'hF0) begin failures++; $display("FAIL areset_setup actual=%h expected=f0", value); end
    live_mode = 1'b0;
    dip_in = 8'h33;
    btn_in = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++; if (value !== 8'h00 || capture_pulse !== 1'b0 || btn_level !== 1'b0 || changed !== 1'b0) begin
      failures++; $display("FAIL areset_clear value=%h pulse=%b level=%b changed=%b expected all 0", value, capture_pulse, btn_level, changed);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k < 9) begin
        checks++; if (value !== 8'h00) begin failures++; $display("FAIL areset_value_early edge=%0d actual=%h expected=00", k, value); end
      end
      if (k == 7) begin
        checks++; if (changed !== 1'b0 || btn_level !== 1'b0) begin
          failures++; $display("FAIL areset_e7 changed=%b level=%b expected 0 0", changed, btn_level);
        end
      end
      if (k == 8) begin
        checks++; if (changed !== 1'b1 || btn_level !== 1'b1) begin
          failures++; $display("FAIL areset_e8 changed=%b level=%b expected 1 1", changed, btn_level);
        end
      end
      if (k == 9) begin
        checks++; if (value !== 8'hCC || capture_pulse !== 1'b1) begin
          failures++; $display("FAIL areset_held_press value=%h pulse=%b expected value=cc pulse=1", value, capture_pulse);
        end
      end
      if (k == 10) begin
        checks++; if (capture_pulse !== 1'b0) begin failures++; $display("FAIL areset_pulse_e10 actual=%b expected=0", capture_pulse); end
      end
    end
  endtask

  task automatic test_random();
    logic m_changed;
    dip_in = 8'($urandom);
    btn_in = 1'b0;
    live_mode = 1'b0;
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 11) == 0) dip_in = 8'($urandom);
      if ($urandom_range(0, 9) == 0) btn_in = ~btn_in;
      if ($urandom_range(0, 59) == 0) live_mode = ~live_mode;
      tick();
      m_changed = (m_value != rev8(m_dip));
      checks++; if (value !== m_value) begin
        failures++; $display("FAIL rand_value cyc=%0d actual=%h expected=%h", k, value, m_value);
      end
      checks++; if (capture_pulse !== m_pulse) begin
        failures++; $display("FAIL rand_pulse cyc=%0d actual=%b expected=%b", k, capture_pulse, m_pulse);
      end
      checks++; if (btn_level !== m_lvl) begin
        failures++; $display("FAIL rand_btn_level cyc=%0d actual=%b expected=%b", k, btn_level, m_lvl);
      end
      checks++; if (changed !== m_changed) begin
        failures++; $display("FAIL rand_changed cyc=%0d actual=%b expected=%b", k, changed, m_changed);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_latch_idle();
    test_press();
    test_bounce();
    test_glitch();
    test_live();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
